// File: rtl/spi_host_master_if.sv
// ---------------------------------------------------------------------------
// spi_host_master_if
//   Parallel command bus between a host and the SPI host master.
//   master modport : the command issuer (drives start/cmd/din)
//   slave  modport : spi_host_master (drives ready/busy/done/rd_data/rd_valid)
//   Signals:
//     start    command request, accepted when start && ready
//     cmd      00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//     din      payload (address or data)
//     ready    a command can be accepted this cycle
//     busy     a frame is in progress
//     done     1-cycle pulse at frame end
//     rd_data  last byte received on a rd-data frame
//     rd_valid 1-cycle pulse with done on rd-data frames
// ---------------------------------------------------------------------------
interface spi_host_master_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output start, cmd, din,
        input  ready, busy, done, rd_data, rd_valid
    );

    modport slave (
        input  start, cmd, din,
        output ready, busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/spi_host_master.sv
// ---------------------------------------------------------------------------
// spi_host_master
//   Host-side SPI master. Serialises parallel RAM commands into frames on
//   SS_n/MOSI (one bit per clk) and, for rd-data commands, collects the reply
//   from MISO after a slave turnaround window.
//   Frame: SEL (MOSI=cmd[1]) -> SHIFT {cmd,din} MSB first -> [WAIT_RD -> RECV]
//          -> GAP (SS_n high, done pulse) -> IDLE or next SEL.
//   Ports:
//     clk     system clock (also the SPI bit clock)
//     rst_n   asynchronous active-low reset
//     cmd_if  command bus (slave modport of spi_host_master_if)
//     SS_n    slave select, active low
//     MOSI    serial data to slave, MSB first
//     MISO    serial data from slave, MSB first, sampled only in RECV
//   Parameters: DATA_W payload width, RD_WAIT turnaround cycles (>=1),
//     GAP inter-frame high cycles (>=1, must not exceed 2+DATA_W+RD_WAIT).
//   Optional feature: define SPI_HOST_MASTER_QUEUE_EN for a one-entry
//     command buffer (ready = buffer empty; a buffered command launches SEL
//     directly from the last GAP cycle).
// ---------------------------------------------------------------------------
module spi_host_master #(
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_host_master_if.slave  cmd_if,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);
    localparam int BODY_W = 2 + DATA_W;
    localparam int CNT_W  = $clog2(BODY_W + RD_WAIT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(BODY_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_WAIT_RD,
        ST_RECV,
        ST_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BODY_W-1:0]   shreg_q, shreg_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                ready;
    logic                accept;
    logic                have_cmd;
    logic                launch;
    logic [1:0]          launch_cmd;
    logic [DATA_W-1:0]   launch_din;
    logic                done;
    logic                rd_valid;

`ifdef SPI_HOST_MASTER_QUEUE_EN
    logic                buf_vld_q, buf_vld_d;
    logic [1:0]          buf_cmd_q, buf_cmd_d;
    logic [DATA_W-1:0]   buf_din_q, buf_din_d;

    // A buffered command always has priority over the live inputs; while it
    // is held, ready is low so the two can never compete.
    assign ready      = ~buf_vld_q;
    assign accept     = cmd_if.start && ready;
    assign have_cmd   = buf_vld_q || accept;
    assign launch_cmd = buf_vld_q ? buf_cmd_q : cmd_if.cmd;
    assign launch_din = buf_vld_q ? buf_din_q : cmd_if.din;
`else
    assign ready      = (state_q == ST_IDLE);
    assign accept     = cmd_if.start && ready;
    assign have_cmd   = accept;
    assign launch_cmd = cmd_if.cmd;
    assign launch_din = cmd_if.din;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        launch    = 1'b0;
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        done      = 1'b0;
        rd_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = have_cmd;
            end
            ST_SEL: begin
                // Path-select bit: cmd[1] is already the shift register MSB,
                // so it is presented here without shifting.
                SS_n    = 1'b0;
                MOSI    = shreg_q[BODY_W-1];
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                SS_n    = 1'b0;
                MOSI    = shreg_q[BODY_W-1];
                shreg_d = {shreg_q[BODY_W-2:0], 1'b0};
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d   = '0;
                    state_d = (cmd_q == 2'b11) ? ST_WAIT_RD : ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_RD: begin
                SS_n = 1'b0;
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RECV: begin
                SS_n = 1'b0;
                rx_d = {rx_q[DATA_W-2:0], MISO};
                if (cnt_q == RECV_LAST) begin
                    // Final bit lands on the same edge that enters GAP, so
                    // rd_data is valid alongside done/rd_valid.
                    rd_data_d = rx_d;
                    cnt_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                done     = (cnt_q == '0);
                rd_valid = done && (cmd_q == 2'b11);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    launch  = have_cmd;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_d = ST_SEL;
            cmd_d   = launch_cmd;
            shreg_d = {launch_cmd, launch_din};
            cnt_d   = '0;
        end
    end

`ifdef SPI_HOST_MASTER_QUEUE_EN
    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_cmd_d = buf_cmd_q;
        buf_din_d = buf_din_q;
        if (launch && buf_vld_q) begin
            buf_vld_d = 1'b0;
        end
        // A command that cannot launch this cycle is parked in the buffer.
        if (accept && !launch) begin
            buf_vld_d = 1'b1;
            buf_cmd_d = cmd_if.cmd;
            buf_din_d = cmd_if.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld_q <= 1'b0;
            buf_cmd_q <= '0;
            buf_din_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_cmd_q <= buf_cmd_d;
            buf_din_q <= buf_din_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign cmd_if.ready    = ready;
    assign cmd_if.busy     = (state_q != ST_IDLE);
    assign cmd_if.done     = done;
    assign cmd_if.rd_data  = rd_data_q;
    assign cmd_if.rd_valid = rd_valid;
endmodule

// File: tb/tb_spi_host_master.sv
`timescale 1ns/1ps
module tb_spi_host_master;
    localparam int DATA_W     = 8;
    localparam int RD_WAIT    = 2;
    localparam int GAP        = 1;
    localparam int BODY_W     = 2 + DATA_W;
    // Index (counting SS_n-low cycles from 0) of the first reply bit.
    localparam int RECV_FIRST = 1 + BODY_W + RD_WAIT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MISO  = 1'b0;
    logic SS_n;
    logic MOSI;

    spi_host_master_if #(.DATA_W(DATA_W)) bus ();

    spi_host_master #(
        .DATA_W (DATA_W),
        .RD_WAIT(RD_WAIT),
        .GAP    (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd_if(bus),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [1:0]        cmd;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] rd;     // rd_data expected at frame end
        int                acc;    // cycle in which start was presented
        bit                timed;  // accepted from idle -> fixed latency
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] reply_q[$];
    logic [DATA_W-1:0] model_rd = '0;

    // ---------------- monitor ----------------
    logic mon_bits[$];
    int   lo_cnt      = 0;
    int   hi_run      = 0;
    int   last_hi_run = 0;
    logic prev_ss     = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_bits.delete();
            lo_cnt  = 0;
            hi_run  = 0;
            prev_ss = 1'b1;
        end else begin
            if (SS_n == 1'b0) begin
                if (prev_ss) begin
                    last_hi_run = hi_run;
                    hi_run      = 0;
                end
                mon_bits.push_back(MOSI);
                lo_cnt++;
            end else begin
                hi_run++;
            end
            prev_ss = SS_n;

            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    logic [BODY_W:0] got;
                    bit rd;
                    e   = sb_q.pop_front();
                    rd  = (e.cmd == 2'b11);
                    got = '0;
                    for (int i = 0; i <= BODY_W; i++)
                        got = {got[BODY_W-1:0], (i < mon_bits.size()) ? mon_bits[i] : 1'b0};
                    check("ss_n_at_done", SS_n, 1);
                    check("ss_low_cycles", lo_cnt, 1 + BODY_W + (rd ? RD_WAIT + DATA_W : 0));
                    check("mosi_bits", got, {e.cmd[1], e.cmd, e.din});
                    check("rd_valid", bus.rd_valid, rd);
                    check("rd_data", bus.rd_data, e.rd);
                    if (e.timed)
                        check("latency", cyc - e.acc + 1,
                              3 + BODY_W + (rd ? RD_WAIT + DATA_W : 0));
                end
                mon_bits.delete();
                lo_cnt = 0;
            end else if (bus.rd_valid) begin
                check("rd_valid_without_done", 1, 0);
            end
        end
    end

    // ---------------- SPI slave model ----------------
    int                s_idx   = 0;
    logic              s_c1    = 1'b0;
    bit                s_rd    = 0;
    logic [DATA_W-1:0] s_reply = '0;

    always @(negedge clk) begin
        if (!rst_n || SS_n) begin
            s_idx = 0;
            s_rd  = 0;
            MISO  = 1'($urandom);
        end else begin
            if (s_idx == 1) s_c1 = MOSI;
            if (s_idx == 2) s_rd = s_c1 && MOSI;
            if (s_rd && s_idx >= RECV_FIRST && s_idx < RECV_FIRST + DATA_W) begin
                if (s_idx == RECV_FIRST) begin
                    if (reply_q.size() == 0) begin
                        check("slave_reply_available", 0, 1);
                        s_reply = '0;
                    end else begin
                        s_reply = reply_q.pop_front();
                    end
                end
                MISO = s_reply[DATA_W-1-(s_idx-RECV_FIRST)];
            end else begin
                MISO = 1'($urandom);
            end
            s_idx++;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] c, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] rep, input bit track);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus.start = 1'b1;
        bus.cmd   = c;
        bus.din   = d;
        if (track) begin
            e.cmd   = c;
            e.din   = d;
            e.acc   = cyc;
            e.timed = !bus.busy;
            if (c == 2'b11) begin
                model_rd = rep;
                reply_q.push_back(rep);
            end
            e.rd = model_rd;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb_q.size() != 0 || bus.busy) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0 || bus.busy) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.cmd   = 2'b00;
        bus.din   = '0;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ss_n",     SS_n,         1);
        check("rst_mosi",     MOSI,         0);
        check("rst_busy",     bus.busy,     0);
        check("rst_ready",    bus.ready,    1);
        check("rst_done",     bus.done,     0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data",  bus.rd_data,  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed write-addr and read-data frames.
        issue(2'b00, 8'hA5, 8'h00, 1);
        drain();
        issue(2'b11, 8'h00, 8'h3C, 1);
        drain();
        check("rd_data_hold_3c", bus.rd_data, 8'h3C);

`ifndef SPI_HOST_MASTER_QUEUE_EN
        // Start while busy must be ignored.
        issue(2'b01, 8'h5A, 8'h00, 1);
        repeat (3) @(negedge clk);
        check("ready_while_busy", bus.ready, 0);
        bus.start = 1'b1;
        bus.cmd   = 2'b11;
        bus.din   = 8'hC3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();
        repeat (30) @(negedge clk);
        check("no_extra_frame_busy", bus.busy, 0);
        issue(2'b10, 8'h81, 8'h00, 1);
        drain();
`else
        // Back-to-back commands: second one is buffered.
        issue(2'b01, 8'h11, 8'h00, 1);
        issue(2'b00, 8'h22, 8'h00, 1);
        drain();
        check("gap_between_frames", last_hi_run, GAP);
`endif

        // Randomised command stream.
        for (int n = 0; n < 24; n++) begin
            logic [1:0]        c;
            logic [DATA_W-1:0] d;
            logic [DATA_W-1:0] r;
            c = 2'($urandom);
            d = DATA_W'($urandom);
            r = DATA_W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(c, d, r, 1);
        end
        drain();

        // Reset in the middle of a read-data SHIFT.
        issue(2'b11, 8'h77, 8'h00, 0);
        repeat (4) @(negedge clk);
        check("pre_abort_ss_low", SS_n, 0);
        #2;
        rst_n    = 1'b0;
        model_rd = '0;
        #1;
        check("abort_ss_n",     SS_n,         1);
        check("abort_busy",     bus.busy,     0);
        check("abort_done",     bus.done,     0);
        check("abort_rd_valid", bus.rd_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(2'b11, 8'h00, 8'hE7, 1);
        drain();
        check("post_abort_rd_data", bus.rd_data, 8'hE7);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        check("reply_queue_empty", reply_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
